comp_seq: RTL

- Parametrised, multi-cycle magnitude comparator; successor to the fixed 8-bit combinational comparator.
- Compares two WIDTH-bit operands SLICE bits per cycle, MSB slice first, and exits early on the first unequal slice.
- Valid/ready handshake on input and output, so rank-score compare units in the PageRank datapath can be time-shared and stalled.

---
 rtl/comp_pkg.sv | 26 ++
 rtl/comp_slice.sv | 17 +
 rtl/comp_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types for the sliced magnitude comparator: FSM states, one-hot result
// encoding and the slice-count helper used at elaboration.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions line up with res_t below: {eq, gt, lt}.
  localparam logic [2:0] RES_LT = 3'b001;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b100;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } res_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/comp_slice.sv
// Combinational SLICE-bit unsigned comparator; exactly one of lt/gt/eq is high.
// No state, no latency, no backpressure.
module comp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/comp_seq.sv
// Multi-cycle MSB-first sliced comparator, result k cycles after accept (k = slices examined);
// accepts only in IDLE and holds the result in DONE until out_ready. SIGNED_CMP_EN adds port sgn.
module comp_seq
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
`ifdef SIGNED_CMP_EN
  input  logic             sgn,
`endif
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((SLICE < 1) || (NSLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_cfg_err
      $error("comp_seq: WIDTH must be a nonzero multiple of SLICE");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  res_t             res_q, res_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             s_lt, s_gt, s_eq;
  logic [WIDTH-1:0] msb_flip;

  // Inverting both MSBs maps two's complement onto offset binary, so the
  // unsigned slice compare orders signed operands correctly.
`ifdef SIGNED_CMP_EN
  assign msb_flip = sgn ? (WIDTH'(1) << (WIDTH - 1)) : '0;
`else
  assign msb_flip = '0;
`endif

  assign a_sl = SLICE'(a_q >> (idx_q * SLICE));
  assign b_sl = SLICE'(b_q >> (idx_q * SLICE));

  comp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a ^ msb_flip;
          b_d     = b ^ msb_flip;
          idx_d   = IDX_W'(NSLICE - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (s_gt) begin
          res_d   = RES_GT;
          state_d = DONE;
        end else if (s_lt) begin
          res_d   = RES_LT;
          state_d = DONE;
        end else if (s_eq && (idx_q == '0)) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        res_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lt        = res_q.lt;
  assign gt        = res_q.gt;
  assign eq        = res_q.eq;

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot({lt, gt, eq}));
  a_idle_clear: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> ({lt, gt, eq} == 3'b000));
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable({lt, gt, eq})));

endmodule
